// File: rtl/led_step_scheduler_pkg.sv
// Shared definitions for the LED step scheduler.
//   led_state_t              : 2-bit FSM state, also the encoding of `mode`
//   LED_DEBOUNCE_DEFAULT     : default stable-sample count for the button
//   LED_AUTO_PERIOD_DEFAULT  : default cycles between auto-run step pulses
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MANUAL = 2'b01,
        ST_AUTO   = 2'b10,
        ST_PAUSED = 2'b11
    } led_state_t;

    localparam int unsigned LED_DEBOUNCE_DEFAULT    = 4;
    localparam int unsigned LED_AUTO_PERIOD_DEFAULT = 10;

endpackage

// File: rtl/led_step_scheduler_if.sv
// Control/status bundle between the user-input side and the scheduler.
//   button_raw : raw, asynchronous, bouncy push-button level
//   auto_req   : synchronous level requesting timer-paced stepping
//   pause      : synchronous level freezing the sequence
//   step       : registered step enable for the LED block
//   mode       : registered FSM state (00 IDLE, 01 MANUAL, 10 AUTO, 11 PAUSED)
// master drives the requests; slave (the scheduler) drives step/mode.
interface led_step_scheduler_if;

    logic       button_raw;
    logic       auto_req;
    logic       pause;
    logic       step;
    logic [1:0] mode;

    modport master (
        output button_raw,
        output auto_req,
        output pause,
        input  step,
        input  mode
    );

    modport slave (
        input  button_raw,
        input  auto_req,
        input  pause,
        output step,
        output mode
    );

endinterface

// File: rtl/led_step_scheduler_button_debounce.sv
// Two-flop synchroniser plus debounce filter for the push-button.
//   clk, rst   : system clock, asynchronous active-high reset
//   button_raw : raw button level (asynchronous to clk)
//   button_db  : debounced level; flips only after DEBOUNCE_CYCLES
//                consecutive synchronised samples differ from it
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic button_db
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          btn_s;
    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1    <= 1'b0;
            btn_s     <= 1'b0;
            count     <= '0;
            button_db <= 1'b0;
        end else begin
            sync_1 <= button_raw;
            btn_s  <= sync_1;
            if (btn_s != button_db) begin
                // The sample that completes the run flips the output and
                // restarts the count, so the next change needs a full run.
                if (count == LAST) begin
                    button_db <= ~button_db;
                    count     <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/led_step_scheduler.sv
// Step scheduler for the colour-stepping LED block.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : led_step_scheduler_if.slave
//              in : button_raw, auto_req, pause
//              out: step (registered), mode (registered FSM state)
// Priority pause > debounced button > auto_req. MANUAL steps every cycle,
// AUTO steps once every AUTO_PERIOD cycles, PAUSED holds step low.
module led_step_scheduler
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = LED_DEBOUNCE_DEFAULT,
    parameter int unsigned AUTO_PERIOD     = LED_AUTO_PERIOD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    led_step_scheduler_if.slave   bus
);

    localparam int unsigned ACW = $clog2(AUTO_PERIOD);
    localparam logic [ACW-1:0] AUTO_LAST = ACW'(AUTO_PERIOD - 1);

    logic           button_db;
    led_state_t     state;
    led_state_t     state_next;
    logic [ACW-1:0] auto_count;
    logic           step_q;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .button_raw(bus.button_raw),
        .button_db (button_db)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.pause)         state_next = ST_PAUSED;
                else if (button_db)    state_next = ST_MANUAL;
                else if (bus.auto_req) state_next = ST_AUTO;
            end
            ST_MANUAL: begin
                if (bus.pause)         state_next = ST_PAUSED;
                else if (!button_db)   state_next = ST_IDLE;
            end
            ST_AUTO: begin
                if (bus.pause)         state_next = ST_PAUSED;
                else if (button_db)    state_next = ST_MANUAL;
                else if (!bus.auto_req) state_next = ST_IDLE;
            end
            ST_PAUSED: begin
                if (!bus.pause)        state_next = ST_IDLE;
            end
            default:                   state_next = ST_IDLE;
        endcase
    end

    // step and mode are loaded from state_next on the same edge, so the
    // LED block always sees a step value that matches the reported mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            auto_count <= '0;
            step_q     <= 1'b0;
        end else begin
            state <= state_next;

            if (state_next == ST_AUTO && state != ST_AUTO) begin
                auto_count <= '0;
            end else if (state_next == ST_AUTO && state == ST_AUTO) begin
                auto_count <= (auto_count == AUTO_LAST) ? '0 : auto_count + 1'b1;
            end

            step_q <= (state_next == ST_MANUAL) ||
                      (state == ST_AUTO && state_next == ST_AUTO &&
                       auto_count == AUTO_LAST);
        end
    end

    assign bus.step = step_q;
    assign bus.mode = state;

endmodule

// File: tb/tb_led_step_scheduler.sv
// Scoreboard bench for led_step_scheduler: a behavioural model pushes the
// expected step/mode/debounced level per clock edge; a monitor pops and
// compares on the falling edge.
module tb_led_step_scheduler;
    import led_ctrl_pkg::*;

    localparam int D = 4;
    localparam int P = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_step_scheduler_if bus();

    led_step_scheduler #(
        .DEBOUNCE_CYCLES(D),
        .AUTO_PERIOD    (P)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       step;
        logic [1:0] mode;
        logic       db;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model ----------------
    bit   m_s1, m_s2, m_db;
    bit   hist[$];          // synchronised samples seen by the filter
    int   m_state;          // 0 IDLE, 1 MANUAL, 2 AUTO, 3 PAUSED
    int   since_entry;      // edges spent in AUTO since entering it

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0;
        hist.delete();
        m_state = 0;
        since_entry = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit   seen = m_s2;
        bit   db_old = m_db;
        bit   flip;
        int   nxt;
        exp_t e;
        m_s2 = m_s1;
        m_s1 = bus.button_raw;
        hist.push_back(seen);
        if (hist.size() > D) void'(hist.pop_front());
        if (hist.size() == D) begin
            flip = 1;
            foreach (hist[i]) if (hist[i] == db_old) flip = 0;
            if (flip) m_db = ~db_old;
        end
        nxt = m_state;
        case (m_state)
            0: nxt = bus.pause ? 3 : db_old ? 1 : bus.auto_req ? 2 : 0;
            1: nxt = bus.pause ? 3 : !db_old ? 0 : 1;
            2: nxt = bus.pause ? 3 : db_old ? 1 : !bus.auto_req ? 0 : 2;
            default: nxt = bus.pause ? 3 : 0;
        endcase
        e.step = 1'b0;
        if (nxt == 2 && m_state != 2) since_entry = 0;
        else if (nxt == 2 && m_state == 2) begin
            since_entry++;
            if (since_entry % P == 0) e.step = 1'b1;
        end
        if (nxt == 1) e.step = 1'b1;
        m_state = nxt;
        e.mode = 2'(nxt);
        e.db   = m_db;
        exp_q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                checks++;
                if (bus.step !== 1'b0 || bus.mode !== 2'b00) begin
                    errors++;
                    $display("FAIL in_reset: step=%b mode=%b required step=0 mode=00",
                             bus.step, bus.mode);
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.step !== e.step) begin
                    errors++;
                    $display("FAIL step @%0t: got %b required %b", $time, bus.step, e.step);
                end
                checks++;
                if (bus.mode !== e.mode) begin
                    errors++;
                    $display("FAIL mode @%0t: got %b required %b", $time, bus.mode, e.mode);
                end
                checks++;
                if (dut.u_debounce.button_db !== e.db) begin
                    errors++;
                    $display("FAIL button_db @%0t: got %b required %b",
                             $time, dut.u_debounce.button_db, e.db);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit b, input bit a, input bit p, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.button_raw = b;
            bus.auto_req   = a;
            bus.pause      = p;
        end
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.step !== 1'b0 || bus.mode !== 2'b00 ||
            dut.auto_count !== '0 || dut.u_debounce.count !== '0 ||
            dut.u_debounce.button_db !== 1'b0) begin
            errors++;
            $display("FAIL %s: step=%b mode=%b auto_cnt=%0d db_cnt=%0d db=%b required all 0",
                     tag, bus.step, bus.mode, dut.auto_count,
                     dut.u_debounce.count, dut.u_debounce.button_db);
        end
        bus.button_raw = 0; bus.auto_req = 0; bus.pause = 0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bit b, a, p;
        int seg, rate;
        bus.button_raw = 0; bus.auto_req = 0; bus.pause = 0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        drive(0, 0, 0, 3);
        drive(1, 0, 0, 20);                     // press and hold
        drive(0, 0, 0, 15);                     // release
        for (int r = 0; r < 5; r++) begin       // bounce: 3 high, 1 low
            drive(1, 0, 0, 3);
            drive(0, 0, 0, 1);
        end
        drive(0, 0, 0, 10);
        drive(0, 1, 0, 45);                     // auto pulses
        drive(0, 0, 0, 5);
        drive(0, 1, 0, 15);                     // pause mid-count
        drive(0, 1, 1, 7);
        drive(0, 1, 0, 25);
        drive(1, 1, 0, $urandom_range(10, 20)); // button overrides auto
        drive(0, 1, 0, 30);
        drive(0, 0, 0, 5);

        drive(1, 0, 0, 10);                     // reset mid-MANUAL
        async_reset_check("reset_mid_manual");
        drive(0, 1, 0, 17);                     // reset mid-AUTO
        async_reset_check("reset_mid_auto");
        drive(0, 1, 0, 25);

        b = 0; a = 0; p = 0;
        for (int s = 0; s < 120; s++) begin
            seg  = $urandom_range(5, 40);
            rate = ($urandom_range(0, 2) == 0) ? 2 : 30;
            for (int i = 0; i < seg; i++) begin
                if ($urandom_range(0, rate - 1) == 0) b = ~b;
                if ($urandom_range(0, 24) == 0) a = ~a;
                if ($urandom_range(0, 39) == 0) p = ~p;
                drive(b, a, p, 1);
            end
        end
        drive(0, 0, 0, 10);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
